sap1_mar: RTL and testbench
===========================

Name: sap1_mar

Overview:
- Memory Address Register for the SAP-1 CPU.
- Latches a RAM address from the W-bus on a clock edge when load is asserted, and drives that address continuously to the RAM.
- Supports auto-increment (bulk memory fill) and a program-mode switch override, so the RAM can be addressed from front-panel switches.

Parameters:
ADDR_W, 4, address width in bits; Q, D and sw all use this width.

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
CLR_N  input  1  asynchronous active-low reset.
D  input  ADDR_W  address from the W-bus (low nibble of bus in SAP-1).
load  input  1  active-high load enable (the inverse of the CPU's Lm control bit).
inc  input  1  active-high increment enable.
prog  input  1  program mode select; 1 = switch address drives Q.
sw  input  ADDR_W  front-panel address switches.
Q  output  ADDR_W  address to RAM.
wrap  output  1  one-cycle pulse when an increment wraps all-ones to zero.

Behaviour:
- Reset: CLR_N low asynchronously forces the internal register to 0 and wrap to 0. Q reads 0 when prog=0.
- Reset release: takes effect at the next rising CLK edge.
- Rising CLK edge, priority order:
  - load=1: register <= D. Load wins over inc.
  - else inc=1: register <= register + 1, modulo 2^ADDR_W.
  - else: hold.
- Load latency: the value of D sampled at the edge appears on Q immediately after that edge (one-edge latency, no extra pipeline).
- Continuous load: with load held high for N consecutive edges, the register tracks D each edge. The last sampled value is retained after load falls.
- Wrap-around: when inc causes all-ones to 0 (load=0), wrap=1 for exactly the following cycle.
  - wrap is registered and is 0 on all other cycles.
  - A load of 0 never asserts wrap.
- Output mux: Q = prog ? sw : register (combinational, see Optional Feature).
  - The register keeps operating (load/inc) regardless of prog.
- D and sw are only sampled or passed; there are no X-propagation checks.
- No other outputs; no bus tristate (the bus driver lives elsewhere).

Optional Feature:
MAR_PROG_MUX_EN
- Defined: prog/sw mux active as described in Behaviour.
- Undefined: prog and sw remain in the port list but are ignored, and Q is always the register value.

Test Plan:
- Reset: CLR_N=0 mid-cycle with register=4'hA -> Q=0 immediately without waiting for a clock edge; wrap=0.
- Load pulse: D increments every cycle; load=1 for 3 edges while D goes 5,6,7 -> Q=5,6,7 after each edge. load=0 for 6 edges -> Q holds 7 while D keeps changing.
- Increment and wrap: load D=4'hE, then inc=1 for 3 edges -> Q=F, 0, 1. wrap=1 only in the cycle after F->0.
- Priority: load=1, inc=1, D=3 with register=9 -> Q=3 (not 4 or A).
- Program mode (MAR_PROG_MUX_EN defined): register=2, prog=1, sw=4'hC -> Q=C combinationally. prog=0 -> Q=2. Loading D=6 while prog=1 -> Q stays C, then shows 6 after prog=0.
- Soak: 50 iterations of load high 3 cycles / low 6 cycles with an incrementing D -> Q always equals D sampled at the last load-high edge.

Source files
------------

// File: rtl/sap1_mar.sv
// rtl/sap1_mar.sv - SAP-1 memory address register with load/increment and wrap pulse.
// Define MAR_PROG_MUX_EN to let prog/sw override Q from the front-panel switches.
module sap1_mar #(
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [ADDR_W-1:0] D,
  input  logic              load,
  input  logic              inc,
  input  logic              prog,
  input  logic [ADDR_W-1:0] sw,
  output logic [ADDR_W-1:0] Q,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_q, wrap_d;

  // Load outranks increment; wrap flags only an increment rolling all-ones to zero.
  always_comb begin
    addr_d = addr_q;
    wrap_d = 1'b0;
    if (load) begin
      addr_d = D;
    end else if (inc) begin
      addr_d = addr_q + ONE;
      wrap_d = &addr_q;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

`ifdef MAR_PROG_MUX_EN
  assign Q = prog ? sw : addr_q;
`else
  // Switch inputs stay on the port list but have no effect in this build.
  logic unused_sw;
  assign unused_sw = ^{prog, sw};
  assign Q = addr_q;
`endif

endmodule

// File: tb/tb_sap1_mar.sv
// tb/tb_sap1_mar.sv - scoreboard bench for sap1_mar against a behavioural address model.
module tb_sap1_mar;

  localparam int AW   = 4;
  localparam int MODV = 1 << AW;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic [AW-1:0] d = '0;
  logic          load = 1'b0;
  logic          inc = 1'b0;
  logic          prog = 1'b0;
  logic [AW-1:0] sw = '0;
  logic [AW-1:0] q;
  logic          wrap;

  int tests = 0;
  int fails = 0;
  bit done = 1'b0;

  int m_reg = 0;
  bit m_wrap = 1'b0;

  typedef struct {
    int q;
    bit w;
  } exp_t;
  exp_t sb[$];

  sap1_mar #(.ADDR_W(AW)) dut (
    .CLK(clk), .CLR_N(clr_n), .D(d), .load(load), .inc(inc),
    .prog(prog), .sw(sw), .Q(q), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int visible_q(input int r);
`ifdef MAR_PROG_MUX_EN
    return prog ? int'(sw) : r;
`else
    return r;
`endif
  endfunction

  // Reference model: address arithmetic modulo 2^AW, pushing one expectation per edge.
  initial forever begin
    @(negedge clr_n);
    m_reg = 0;
    m_wrap = 1'b0;
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    if (!clr_n) begin
      m_reg = 0;
      m_wrap = 1'b0;
    end else if (load) begin
      m_reg = int'(d);
      m_wrap = 1'b0;
    end else if (inc) begin
      m_wrap = (m_reg == MODV - 1);
      m_reg = (m_reg + 1) % MODV;
    end else begin
      m_wrap = 1'b0;
    end
    e.q = visible_q(m_reg);
    e.w = m_wrap;
    sb.push_back(e);
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!done) begin
      if (sb.size() == 0) begin
        chk("scoreboard_underflow", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("sb_q", int'(q), e.q);
        chk("sb_wrap", int'(wrap), int'(e.w));
      end
    end
  end

  task automatic cycle(input bit l, input bit i, input logic [AW-1:0] dv,
                       input bit p, input logic [AW-1:0] s);
    @(negedge clk);
    load = l;
    inc  = i;
    d    = dv;
    prog = p;
    sw   = s;
    @(posedge clk);
  endtask

  initial begin
    int dv;
    int last;
    repeat (2) cycle(0, 0, 0, 0, 0);
    #1 chk("reset_q", int'(q), 0);
    chk("reset_wrap", int'(wrap), 0);
    @(negedge clk) clr_n = 1'b1;

    // Asynchronous clear mid-cycle
    cycle(1, 0, 4'hA, 0, 0);
    #3 clr_n = 1'b0;
    #1 chk("async_clr_q", int'(q), 0);
    chk("async_clr_wrap", int'(wrap), 0);
    cycle(0, 0, 4'h3, 0, 0);
    @(negedge clk) clr_n = 1'b1;

    // Load pulse then hold while D keeps moving
    for (int k = 5; k <= 7; k++) cycle(1, 0, AW'(k), 0, 0);
    #1 chk("load_pulse_q", int'(q), 7);
    for (int k = 8; k < 14; k++) cycle(0, 0, AW'(k), 0, 0);
    #1 chk("load_hold_q", int'(q), 7);

    // Increment across the wrap point
    cycle(1, 0, 4'hE, 0, 0);
    cycle(0, 1, 0, 0, 0);
    #1 chk("inc_f_wrap", int'(wrap), 0);
    cycle(0, 1, 0, 0, 0);
    #1 chk("inc_wrap_q", int'(q), 0);
    chk("inc_wrap_pulse", int'(wrap), 1);
    cycle(0, 1, 0, 0, 0);
    #1 chk("inc_after_wrap_q", int'(q), 1);
    chk("inc_after_wrap_pulse", int'(wrap), 0);

    // Load beats increment; loading zero never flags wrap
    cycle(1, 0, 4'h9, 0, 0);
    cycle(1, 1, 4'h3, 0, 0);
    #1 chk("priority_q", int'(q), 3);
    cycle(1, 0, 4'hF, 0, 0);
    cycle(1, 1, 4'h0, 0, 0);
    #1 chk("load_zero_wrap", int'(wrap), 0);

`ifdef MAR_PROG_MUX_EN
    cycle(1, 0, 4'h2, 0, 0);
    @(negedge clk);
    load = 1'b0;
    prog = 1'b1;
    sw = 4'hC;
    #1 chk("prog_sw_q", int'(q), 12);
    cycle(1, 0, 4'h6, 1, 4'hC);
    #1 chk("prog_load_hidden_q", int'(q), 12);
    @(negedge clk);
    load = 1'b0;
    prog = 1'b0;
    #1 chk("prog_off_q", int'(q), 6);
`endif

    // Soak: three load edges then six idle edges, D always incrementing
    dv = 0;
    for (int it = 0; it < 50; it++) begin
      for (int k = 0; k < 3; k++) begin
        cycle(1, 0, AW'(dv), 0, 0);
        last = dv % MODV;
        dv++;
      end
      for (int k = 0; k < 6; k++) begin
        cycle(0, 0, AW'(dv), 0, 0);
        dv++;
      end
      #1 chk("soak_q", int'(q), last);
    end

    // Fully random traffic including switch override
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
            AW'($urandom), ($urandom_range(0, 3) == 0), AW'($urandom));
    end

    @(negedge clk);
    load = 1'b0;
    inc = 1'b0;
    prog = 1'b0;
    @(posedge clk);
    #2 done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
